divider_share_ctrl: RTL and testbench
=====================================

# divider_share_ctrl

Controller that shares one restoring-division iteration core between two requesters. It arbitrates round-robin, loads the winning operands, and sequences WIDTH shift/subtract iterations. It detects divide-by-zero and holds the result until the consumer accepts it. It sits between the instruction-side and DMA-side division clients and the arithmetic datapath.

## Interface
- WIDTH, 8, operand/result width in bits; iteration counter is $clog2(WIDTH)+1 bits
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- req0_valid  input  1  requester 0 has operands
- req0_ready  output  1  requester 0 operands accepted this cycle
- req0_dividend / req0_divisor  input  WIDTH  requester 0 operands
- req1_valid, req1_ready, req1_dividend, req1_divisor: same as requester 0, for requester 1
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  1  index of requester that owns the result
- rsp_quotient  output  WIDTH  unsigned quotient
- rsp_remainder  output  WIDTH  unsigned remainder
- rsp_dbz  output  1  divisor was zero
- busy  output  1  high in every state except IDLE

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: grant among valid requesters. If both are valid, grant the one named by the priority pointer. Pointer resets to 0. After each grant it points to the non-granted port. reqN_ready is combinational, high only for the granted port in IDLE. The handshake latches operands and the id.
- Accept with divisor != 0: IDLE -> LOAD.
- Accept with divisor == 0: IDLE -> DONE directly. Outputs are quotient = all ones, remainder = dividend, rsp_dbz = 1.
- LOAD (1 cycle): core A = 0, Q = dividend, M = divisor. Count = WIDTH. Goes to RUN.
- RUN (WIDTH cycles), one iteration per cycle:
  - Shift {A,Q} left 1 to give {A',Q'}.
  - Compute trial = {1'b0,A'} - {1'b0,M} in WIDTH+1 bits.
  - If trial[WIDTH] = 1 (negative): A = A', Q = {Q'[WIDTH-1:1],0}.
  - Otherwise: A = trial[WIDTH-1:0], Q = {Q'[WIDTH-1:1],1}.
  - Count decrements each cycle; at count == 1 the FSM goes to DONE.
- DONE: rsp_valid = 1. Outputs are stable and equal Q, A, id, and dbz. On rsp_valid && rsp_ready the FSM goes to IDLE. No request is accepted in the same cycle as the response handshake.
- Requests arriving while busy wait. reqN_ready stays low; the requester must hold valid and operands.

## Timing
- Reset values: reqN_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_quotient = 0, rsp_remainder = 0, rsp_dbz = 0, busy = 0. FSM = IDLE, pointer = 0, count = 0.
- Normal latency: the accept edge is T. LOAD runs in cycle T+1 and RUN in cycles T+2 .. T+WIDTH+1. rsp_valid is first high in cycle T+WIDTH+2, which is 10 cycles for WIDTH = 8.
- Divide-by-zero latency: rsp_valid is high in cycle T+1.
- Throughput: at best one result per WIDTH+3 cycles, since IDLE always costs one cycle after DONE.
- Backpressure: rsp_ready low holds DONE and all rsp_* outputs indefinitely.
- Reset mid-operation (LOAD, RUN or DONE): immediate return to reset values. The in-flight result is discarded and no response is issued.
- Pointer updates only on a grant, not on a lone request.

## Structure
- Shared package divider_pkg holds:
  - the state enum (IDLE/LOAD/RUN/DONE);
  - the DBZ_QUOTIENT constant (all ones);
  - the requester-id width constant.
- One sub-module, div_core: A/Q/M registers, the iteration step, and load/step inputs. The controller owns the FSM, counter, arbiter and response register.

## Test plan
- req0 = 100/7 alone -> rsp_valid 10 cycles after accept; q = 14, r = 2, id = 0, dbz = 0.
- req1 = 255/1, then 7/9 -> q = 255, r = 0; then q = 0, r = 7, with id = 1 for both.
- req0 = 13/0 -> rsp_valid the next cycle; q = 8'hFF, r = 13, dbz = 1.
- req0 and req1 valid in the same cycle from reset -> port 0 served first, port 1 second. Repeated simultaneous requests alternate 0, 1, 0, 1.
- rsp_ready held low for 20 cycles in DONE -> outputs stable, busy = 1, and no reqN_ready during that time.
- Assert reset in the 4th RUN cycle -> all outputs at reset values next cycle. A subsequent 200/13 request gives q = 15, r = 5.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and constants for the two-requester divider controller.
package divider_pkg;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam int unsigned ID_W  = 1;

   localparam logic [WIDTH-1:0] DBZ_QUOTIENT = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/divider_share_ctrl_if.sv
// Request/response bundle between the two division clients, the consumer and the controller.
interface divider_share_ctrl_if #(parameter int unsigned WIDTH = divider_pkg::WIDTH);

   logic                          req0_valid;
   logic                          req0_ready;
   logic [WIDTH-1:0]              req0_dividend;
   logic [WIDTH-1:0]              req0_divisor;
   logic                          req1_valid;
   logic                          req1_ready;
   logic [WIDTH-1:0]              req1_dividend;
   logic [WIDTH-1:0]              req1_divisor;
   logic                          rsp_valid;
   logic                          rsp_ready;
   logic [divider_pkg::ID_W-1:0]  rsp_id;
   logic [WIDTH-1:0]              rsp_quotient;
   logic [WIDTH-1:0]              rsp_remainder;
   logic                          rsp_dbz;
   logic                          busy;

   modport master (
      output req0_valid, req0_dividend, req0_divisor,
      output req1_valid, req1_dividend, req1_divisor,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, busy
   );

   modport slave (
      input  req0_valid, req0_dividend, req0_divisor,
      input  req1_valid, req1_dividend, req1_divisor,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, busy
   );

endinterface

// File: rtl/div_core.sv
// Restoring-division iteration core: A/Q/M registers plus one shift/subtract step per cycle.
module div_core
   import divider_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] q_step_c_o,
   output logic [WIDTH-1:0] a_step_c_o
);

   logic [WIDTH-1:0]   a_q, q_q, m_q;
   logic [2*WIDTH-1:0] aq_sh_c;
   logic [WIDTH-1:0]   a_sh_c, q_sh_c;
   logic [WIDTH:0]     trial_c;

   // One iteration: shift {A,Q}, trial-subtract M, restore on a negative result.
   always_comb begin
      aq_sh_c    = {a_q, q_q} << 1;
      a_sh_c     = aq_sh_c[2*WIDTH-1:WIDTH];
      q_sh_c     = aq_sh_c[WIDTH-1:0];
      trial_c    = {1'b0, a_sh_c} - {1'b0, m_q};
      a_step_c_o = a_sh_c;
      q_step_c_o = {q_sh_c[WIDTH-1:1], 1'b0};
      if (!trial_c[WIDTH]) begin
         a_step_c_o = trial_c[WIDTH-1:0];
         q_step_c_o = {q_sh_c[WIDTH-1:1], 1'b1};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q <= '0;
         q_q <= '0;
         m_q <= '0;
      end else if (load_i) begin
         a_q <= '0;
         q_q <= dividend_i;
         m_q <= divisor_i;
      end else if (step_i) begin
         a_q <= a_step_c_o;
         q_q <= q_step_c_o;
      end
   end

endmodule

// File: rtl/divider_share_ctrl.sv
// Round-robin sharing controller for one restoring-division core between two requesters.
module divider_share_ctrl
   import divider_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   divider_share_ctrl_if.slave  bus
);

   state_e            state_q, state_d;
   logic              ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0]  dvd_q, dvd_d, dsr_q, dsr_d;
   logic [WIDTH-1:0]  quot_q, quot_d, rem_q, rem_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic              dbz_q, dbz_d;

   logic              gnt0_c, gnt1_c;
   logic [WIDTH-1:0]  sel_dvd_c, sel_dsr_c;
   logic [WIDTH-1:0]  q_step_c, a_step_c;

   // Pointer names the preferred port when both requesters are valid.
   always_comb begin
      gnt0_c    = (state_q == S_IDLE) && bus.req0_valid && (!bus.req1_valid || !ptr_q);
      gnt1_c    = (state_q == S_IDLE) && bus.req1_valid && (!bus.req0_valid ||  ptr_q);
      sel_dvd_c = gnt1_c ? bus.req1_dividend : bus.req0_dividend;
      sel_dsr_c = gnt1_c ? bus.req1_divisor  : bus.req0_divisor;
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      id_d    = id_q;
      dbz_d   = dbz_q;
      case (state_q)
         S_IDLE: begin
            if (gnt0_c || gnt1_c) begin
               ptr_d = gnt0_c;
               id_d  = ID_W'(gnt1_c);
               dvd_d = sel_dvd_c;
               dsr_d = sel_dsr_c;
               dbz_d = (sel_dsr_c == '0);
               if (sel_dsr_c == '0) begin
                  quot_d  = DBZ_QUOTIENT;
                  rem_d   = sel_dvd_c;
                  state_d = S_DONE;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            cnt_d   = CNT_W'(WIDTH);
            state_d = S_RUN;
         end
         S_RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            // Capture the final iteration straight into the response register.
            if (cnt_q == CNT_W'(1)) begin
               quot_d  = q_step_c;
               rem_d   = a_step_c;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q   <= 1'b0;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dsr_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         id_q    <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dsr_q   <= dsr_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         id_q    <= id_d;
         dbz_q   <= dbz_d;
      end
   end

   div_core u_core (
      .clk        (clk),
      .reset      (reset),
      .load_i     (state_q == S_LOAD),
      .step_i     (state_q == S_RUN),
      .dividend_i (dvd_q),
      .divisor_i  (dsr_q),
      .q_step_c_o (q_step_c),
      .a_step_c_o (a_step_c)
   );

   assign bus.req0_ready    = gnt0_c;
   assign bus.req1_ready    = gnt1_c;
   assign bus.rsp_valid     = (state_q == S_DONE);
   assign bus.rsp_id        = id_q;
   assign bus.rsp_quotient  = quot_q;
   assign bus.rsp_remainder = rem_q;
   assign bus.rsp_dbz       = dbz_q;
   assign bus.busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_divider_share_ctrl.sv
// Directed bench for divider_share_ctrl: vector table plus arbitration, backpressure and reset sequences.
module tb_divider_share_ctrl;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   divider_share_ctrl_if bus ();

   divider_share_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         port;
      logic [7:0] dvd;
      logic [7:0] dsr;
      logic [7:0] eq;
      logic [7:0] er;
      logic       edbz;
      int         elat;
   } vec_t;

   vec_t vecs[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input int port, input logic [7:0] dvd, input logic [7:0] dsr);
      if (port == 0) begin
         bus.req0_valid = 1'b1; bus.req0_dividend = dvd; bus.req0_divisor = dsr;
      end else begin
         bus.req1_valid = 1'b1; bus.req1_dividend = dvd; bus.req1_divisor = dsr;
      end
   endtask

   // Counts cycles after the accept edge until rsp_valid, bounded.
   task automatic wait_rsp(output int lat);
      lat = 1;
      while (!bus.rsp_valid && lat < 30) begin
         tick();
         lat++;
      end
   endtask

   task automatic rsp_handshake();
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
   endtask

   task automatic run_one(input int port, input logic [7:0] dvd, input logic [7:0] dsr,
                          input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                          input int elat);
      int n;
      int lat;
      drive(port, dvd, dsr);
      #1;
      n = 0;
      while (((port == 0) ? !bus.req0_ready : !bus.req1_ready) && n < 20) begin
         tick();
         n++;
      end
      chk("grant", (port == 0) ? int'(bus.req0_ready) : int'(bus.req1_ready), 1);
      chk("other_ready", (port == 0) ? int'(bus.req1_ready) : int'(bus.req0_ready), 0);
      tick();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      wait_rsp(lat);
      chk("latency", lat, elat);
      chk("quotient", int'(bus.rsp_quotient), int'(eq));
      chk("remainder", int'(bus.rsp_remainder), int'(er));
      chk("rsp_id", int'(bus.rsp_id), port);
      chk("rsp_dbz", int'(bus.rsp_dbz), int'(edbz));
      chk("busy_done", int'(bus.busy), 1);
      rsp_handshake();
      chk("valid_after_hs", int'(bus.rsp_valid), 0);
      chk("busy_idle", int'(bus.busy), 0);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_req0_ready"}, int'(bus.req0_ready), 0);
      chk({tag, "_req1_ready"}, int'(bus.req1_ready), 0);
      chk({tag, "_rsp_valid"}, int'(bus.rsp_valid), 0);
      chk({tag, "_rsp_id"}, int'(bus.rsp_id), 0);
      chk({tag, "_quotient"}, int'(bus.rsp_quotient), 0);
      chk({tag, "_remainder"}, int'(bus.rsp_remainder), 0);
      chk({tag, "_dbz"}, int'(bus.rsp_dbz), 0);
      chk({tag, "_busy"}, int'(bus.busy), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      int exp_id;
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      bus.req0_valid = 1'b0; bus.req0_dividend = '0; bus.req0_divisor = '0;
      bus.req1_valid = 1'b0; bus.req1_dividend = '0; bus.req1_divisor = '0;
      bus.rsp_ready  = 1'b0;

      vecs[0] = '{0, 8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 10};
      vecs[1] = '{1, 8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 10};
      vecs[2] = '{1, 8'd7,   8'd9,   8'd0,   8'd7,  1'b0, 10};
      vecs[3] = '{0, 8'd13,  8'd0,   8'hFF,  8'd13, 1'b1, 1};
      vecs[4] = '{1, 8'd200, 8'd13,  8'd15,  8'd5,  1'b0, 10};
      vecs[5] = '{0, 8'd0,   8'd5,   8'd0,   8'd0,  1'b0, 10};
      vecs[6] = '{1, 8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 10};
      vecs[7] = '{1, 8'd1,   8'd0,   8'hFF,  8'd1,  1'b1, 1};

      tick();
      tick();
      check_reset_vals("reset");
      reset = 1'b0;
      tick();

      for (int i = 0; i < 8; i++)
         run_one(vecs[i].port, vecs[i].dvd, vecs[i].dsr, vecs[i].eq, vecs[i].er,
                 vecs[i].edbz, vecs[i].elat);

      // Simultaneous requests from reset: port 0 first, then port 1.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      drive(0, 8'd20, 8'd3);
      drive(1, 8'd50, 8'd7);
      #1;
      chk("both_ready0", int'(bus.req0_ready), 1);
      chk("both_ready1", int'(bus.req1_ready), 0);
      tick();
      bus.req0_valid = 1'b0;
      wait_rsp(lat);
      chk("both_lat0", lat, 10);
      chk("both_id0", int'(bus.rsp_id), 0);
      chk("both_q0", int'(bus.rsp_quotient), 6);
      chk("both_r0", int'(bus.rsp_remainder), 2);
      chk("both_wait_ready1", int'(bus.req1_ready), 0);
      rsp_handshake();
      chk("both_ready1_after", int'(bus.req1_ready), 1);
      tick();
      bus.req1_valid = 1'b0;
      wait_rsp(lat);
      chk("both_id1", int'(bus.rsp_id), 1);
      chk("both_q1", int'(bus.rsp_quotient), 7);
      chk("both_r1", int'(bus.rsp_remainder), 1);
      rsp_handshake();

      for (int r = 0; r < 4; r++) begin
         exp_id = r % 2;
         drive(0, 8'd9, 8'd2);
         drive(1, 8'd9, 8'd4);
         #1;
         chk("rr_ready0", int'(bus.req0_ready), (exp_id == 0) ? 1 : 0);
         chk("rr_ready1", int'(bus.req1_ready), (exp_id == 1) ? 1 : 0);
         tick();
         bus.req0_valid = 1'b0;
         bus.req1_valid = 1'b0;
         wait_rsp(lat);
         chk("rr_id", int'(bus.rsp_id), exp_id);
         chk("rr_q", int'(bus.rsp_quotient), (exp_id == 0) ? 4 : 2);
         rsp_handshake();
      end

      // Backpressure: DONE held for 20 cycles while port 1 waits.
      drive(0, 8'd100, 8'd7);
      #1;
      tick();
      bus.req0_valid = 1'b0;
      wait_rsp(lat);
      drive(1, 8'd9, 8'd3);
      for (int c = 0; c < 20; c++) begin
         tick();
         chk("bp_valid", int'(bus.rsp_valid), 1);
         chk("bp_q", int'(bus.rsp_quotient), 14);
         chk("bp_r", int'(bus.rsp_remainder), 2);
         chk("bp_busy", int'(bus.busy), 1);
         chk("bp_ready0", int'(bus.req0_ready), 0);
         chk("bp_ready1", int'(bus.req1_ready), 0);
      end
      rsp_handshake();
      bus.req1_valid = 1'b0;

      // Reset in the 4th RUN cycle discards the in-flight result.
      drive(1, 8'd50, 8'd7);
      #1;
      chk("mid_grant", int'(bus.req1_ready), 1);
      tick();
      bus.req1_valid = 1'b0;
      for (int c = 0; c < 4; c++) tick();
      chk("mid_busy", int'(bus.busy), 1);
      reset = 1'b1;
      tick();
      check_reset_vals("midrst");
      reset = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         chk("post_rst_valid", int'(bus.rsp_valid), 0);
      end
      run_one(0, 8'd200, 8'd13, 8'd15, 8'd5, 1'b0, 10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
